// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a show-ahead byte FIFO onto a serial line.
// Frame: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// Frames for consecutive FIFO bytes go out back-to-back with no idle clocks between them.

module uart_tx_fifo_drain #(
   parameter int unsigned CLKS_PER_BIT = 10416,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_EN    = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_rd,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned     CntW   = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);
   // Value of the stop-bit index during the final stop bit.
   localparam logic            StopLast = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] baud_cnt_q;
   logic [2:0]      bit_idx_q;
   logic            stop_idx_q;
   logic [7:0]      shift_q;

   logic baud_wrap;
   logic end_of_frame;
   logic data_parity;

   // End of the current bit period.
   assign baud_wrap = (baud_cnt_q == CntMax);

   // Last clock of the last stop bit; a waiting byte is popped here to chain frames.
   assign end_of_frame = (state_q == StStop) && baud_wrap && (stop_idx_q == StopLast);

   // Pop only when a byte is present and the line is free at the next edge.
   assign fifo_rd = !fifo_empty && ((state_q == StIdle) || end_of_frame);

   // Even parity over the latched byte.
   assign data_parity = ^shift_q;

   // Frame sequencer: baud counter, bit stepping and registered line outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         baud_cnt_q <= '0;
         bit_idx_q  <= 3'd0;
         stop_idx_q <= 1'b0;
         shift_q    <= 8'h00;
         tx         <= 1'b1;
         tx_busy    <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;

         if (state_q != StIdle) begin
            baud_cnt_q <= baud_wrap ? '0 : baud_cnt_q + CntOne;
         end

         case (state_q)
            StIdle: begin
               if (fifo_rd) begin
                  shift_q    <= fifo_rdata;
                  state_q    <= StStart;
                  baud_cnt_q <= '0;
                  tx         <= 1'b0;
                  tx_busy    <= 1'b1;
               end
            end

            StStart: begin
               if (baud_wrap) begin
                  state_q   <= StData;
                  bit_idx_q <= 3'd0;
                  tx        <= shift_q[0];
               end
            end

            StData: begin
               if (baud_wrap) begin
                  if (bit_idx_q == 3'd7) begin
                     if (PARITY_EN != 0) begin
                        state_q <= StParity;
                        tx      <= data_parity;
                     end else begin
                        state_q    <= StStop;
                        stop_idx_q <= 1'b0;
                        tx         <= 1'b1;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx        <= shift_q[bit_idx_q + 3'd1];
                  end
               end
            end

            StParity: begin
               if (baud_wrap) begin
                  state_q    <= StStop;
                  stop_idx_q <= 1'b0;
                  tx         <= 1'b1;
               end
            end

            StStop: begin
               if (baud_wrap) begin
                  if (stop_idx_q == StopLast) begin
                     tx_done <= 1'b1;
                     if (fifo_rd) begin
                        // Chain straight into the next start bit.
                        shift_q    <= fifo_rdata;
                        state_q    <= StStart;
                        baud_cnt_q <= '0;
                        tx         <= 1'b0;
                     end else begin
                        state_q <= StIdle;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                     end
                  end else begin
                     stop_idx_q <= 1'b1;
                  end
               end
            end

            default: begin
               state_q <= StIdle;
               tx      <= 1'b1;
               tx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three instances (8N1, 8E1, 8N2) at 4 clocks per bit,
// each fed by a small FIFO model. A per-instance monitor decodes every frame on tx
// and compares it with the byte queued when the stimulus pushed it.

module tb_uart_tx_fifo_drain;

   localparam int CLKS = 4;

   logic       clk;
   logic       rst;
   logic [2:0] push_w;
   logic [7:0] push_data [3];
   logic [2:0] empty_w;
   logic [7:0] rdata_w [3];
   logic [2:0] fifo_rd_w;
   logic [2:0] tx_w;
   logic [2:0] busy_w;
   logic [2:0] done_w;
   logic [2:0] par_w;
   int         frames_w [3];

   int pass_cnt = 0;
   int total_cnt = 0;

   // Results of the most recent run() window.
   int   r_pops;
   int   r_pop_t [4];
   int   r_busy;
   int   r_done;
   int   r_low;
   logic r_hist [0:255];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input int inst,
                                 input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s[u%0d]: got %0h, expected %0h", name, inst, act, exp);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int PAR = (g == 1) ? 1 : 0;
      localparam int SB  = (g == 2) ? 2 : 1;
      localparam int NB  = 9 + PAR + SB;

      logic [7:0] mem [16];
      logic [3:0] wp = 4'd0;
      logic [3:0] rp = 4'd0;
      logic [4:0] cnt = 5'd0;
      logic [7:0] exp_q [$];
      int         frames = 0;
      logic       last_par = 1'b0;

      uart_tx_fifo_drain #(
         .CLKS_PER_BIT(CLKS),
         .STOP_BITS   (SB),
         .PARITY_EN   (PAR)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .fifo_empty(empty_w[g]),
         .fifo_rdata(rdata_w[g]),
         .fifo_rd   (fifo_rd_w[g]),
         .tx        (tx_w[g]),
         .tx_busy   (busy_w[g]),
         .tx_done   (done_w[g])
      );

      assign empty_w[g]  = (cnt == 5'd0);
      assign rdata_w[g]  = mem[rp];
      assign frames_w[g] = frames;
      assign par_w[g]    = last_par;

      // Show-ahead FIFO model.
      always @(posedge clk) begin
         if (push_w[g]) begin
            mem[wp] <= push_data[g];
            wp      <= wp + 4'd1;
         end
         if (fifo_rd_w[g]) rp <= rp + 4'd1;
         cnt <= cnt + {4'd0, push_w[g]} - {4'd0, fifo_rd_w[g]};
      end

      // Scoreboard: expected bytes enter when the stimulus pushes them.
      always @(posedge clk) begin
         if (push_w[g]) exp_q.push_back(push_data[g]);
      end

      always @(negedge clk) begin
         if (fifo_rd_w[g]) check("pop_nonempty", g, {31'd0, empty_w[g]}, 32'd0);
      end

      // Frame monitor: samples tx every clock of a frame against the expected waveform.
      initial begin
         logic [7:0]  exp_b;
         logic [7:0]  got_b;
         logic [15:0] bits;
         logic        par_s;
         logic        aborted;
         int          bad;
         int          busy_bad;
         int          done_bad;
         @(negedge clk);
         forever begin
            if (!rst && tx_w[g] == 1'b0) begin
               check("frame_expected", g, {31'd0, exp_q.size() != 0}, 32'd1);
               exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
               bits = 16'hFFFF;
               bits[0] = 1'b0;
               bits[8:1] = exp_b;
               if (PAR != 0) bits[9] = ^exp_b;
               got_b = 8'h00;
               par_s = 1'b0;
               aborted = 1'b0;
               bad = 0;
               busy_bad = 0;
               done_bad = 0;
               for (int k = 0; k < NB * CLKS; k++) begin
                  if (k > 0) @(negedge clk);
                  if (rst) begin
                     aborted = 1'b1;
                     break;
                  end
                  if (tx_w[g] !== bits[k / CLKS]) bad++;
                  if (busy_w[g] !== 1'b1) busy_bad++;
                  if (k > 0 && done_w[g] !== 1'b0) done_bad++;
                  if (k % CLKS == CLKS / 2) begin
                     if (k / CLKS >= 1 && k / CLKS <= 8) got_b[k / CLKS - 1] = tx_w[g];
                     if (k / CLKS == 9) par_s = tx_w[g];
                  end
               end
               if (!aborted) begin
                  @(negedge clk);
                  check("frame_wave", g, bad, 0);
                  check("frame_byte", g, {24'd0, got_b}, {24'd0, exp_b});
                  check("busy_in_frame", g, busy_bad, 0);
                  check("done_quiet", g, done_bad, 0);
                  check("done_pulse", g, {31'd0, done_w[g]}, 32'd1);
                  last_par = par_s;
                  frames++;
               end
            end else begin
               @(negedge clk);
            end
         end
      end
   end

   // Runs n clocks on instance g, pushing up to three bytes on the first clocks.
   task automatic run(input int g, input int n, input int nb,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      r_pops = 0;
      r_busy = 0;
      r_done = 0;
      r_low  = 0;
      for (int i = 0; i < 4; i++) r_pop_t[i] = -1;
      for (int c = 0; c < n; c++) begin
         push_w[g]    = (c < nb);
         push_data[g] = (c == 0) ? b0 : (c == 1) ? b1 : b2;
         @(negedge clk);
         if (fifo_rd_w[g]) begin
            if (r_pops < 4) r_pop_t[r_pops] = c;
            r_pops++;
         end
         if (busy_w[g]) r_busy++;
         if (done_w[g]) r_done++;
         if (!tx_w[g]) r_low++;
         if (c < 256) r_hist[c] = tx_w[g];
      end
      push_w[g] = 1'b0;
   endtask

   initial begin
      int lo;
      int hi;
      rst = 1'b1;
      push_w = 3'b000;
      for (int i = 0; i < 3; i++) push_data[i] = 8'h00;

      // Reset state.
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         check("rst_tx", g, {31'd0, tx_w[g]}, 32'd1);
         check("rst_busy", g, {31'd0, busy_w[g]}, 32'd0);
         check("rst_done", g, {31'd0, done_w[g]}, 32'd0);
         check("rst_rd", g, {31'd0, fifo_rd_w[g]}, 32'd0);
      end
      rst = 1'b0;

      // Empty FIFO: line stays idle.
      for (int g = 0; g < 3; g++) begin
         run(g, 200, 0, 8'h00, 8'h00, 8'h00);
         check("idle_tx_low", g, r_low, 0);
         check("idle_pops", g, r_pops, 0);
         check("idle_busy", g, r_busy, 0);
         check("idle_done", g, r_done, 0);
      end

      // Single byte 0x55, 8N1.
      run(0, 60, 1, 8'h55, 8'h00, 8'h00);
      check("t1_pops", 0, r_pops, 1);
      check("t1_busy_clks", 0, r_busy, 40);
      check("t1_done", 0, r_done, 1);
      check("t1_frames", 0, frames_w[0], 1);

      // Three bytes back-to-back.
      run(0, 150, 3, 8'hA5, 8'h3C, 8'hFF);
      check("t2_pops", 0, r_pops, 3);
      check("t2_gap1", 0, r_pop_t[1] - r_pop_t[0], 40);
      check("t2_gap2", 0, r_pop_t[2] - r_pop_t[1], 40);
      check("t2_busy_clks", 0, r_busy, 120);
      check("t2_done", 0, r_done, 3);
      check("t2_frames", 0, frames_w[0], 4);

      // Even parity: 0x07 -> 1, 0x03 -> 0; 44-clock frame.
      run(1, 60, 1, 8'h07, 8'h00, 8'h00);
      check("t5_busy_clks", 1, r_busy, 44);
      check("t5_done", 1, r_done, 1);
      check("t5_par_07", 1, {31'd0, par_w[1]}, 32'd1);
      run(1, 60, 1, 8'h03, 8'h00, 8'h00);
      check("t5_par_03", 1, {31'd0, par_w[1]}, 32'd0);
      check("t5_frames", 1, frames_w[1], 2);

      // Two stop bits, 0x00 then 0x5A with no gap.
      run(2, 120, 2, 8'h00, 8'h5A, 8'h00);
      check("t6_pops", 2, r_pops, 2);
      check("t6_gap", 2, r_pop_t[1] - r_pop_t[0], 44);
      check("t6_busy_clks", 2, r_busy, 88);
      lo = 0;
      hi = 0;
      for (int c = 1; c <= 36; c++) if (r_hist[c] == 1'b0) lo++;
      for (int c = 37; c <= 44; c++) if (r_hist[c] == 1'b1) hi++;
      check("t6_low_clks", 2, lo, 36);
      check("t6_stop_clks", 2, hi, 8);
      check("t6_next_start", 2, {31'd0, r_hist[45]}, 32'd0);
      check("t6_frames", 2, frames_w[2], 2);

      // Async reset during data bit 3 of 0x81.
      run(0, 18, 1, 8'h81, 8'h00, 8'h00);
      check("t4_pre_tx", 0, {31'd0, tx_w[0]}, 32'd0);
      check("t4_pre_busy", 0, {31'd0, busy_w[0]}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("t4_rst_tx", 0, {31'd0, tx_w[0]}, 32'd1);
      check("t4_rst_busy", 0, {31'd0, busy_w[0]}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run(0, 40, 0, 8'h00, 8'h00, 8'h00);
      check("t4_post_pops", 0, r_pops, 0);
      check("t4_post_tx_low", 0, r_low, 0);
      check("t4_post_busy", 0, r_busy, 0);
      check("t4_frames", 0, frames_w[0], 4);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
UART transmitter that consumes bytes from the TX-side FIFO and serialises them onto the tx line.
- Sits directly downstream of the 8-deep byte FIFO.
- Uses the FIFO's show-ahead read port: rdata is valid whenever empty=0, and a one-cycle rd pulse advances it.
- Frames are 8N1 by default. Even parity and 2 stop bits are parameter options.
- An internal baud counter makes the block self-contained.

Parameters:
CLKS_PER_BIT, 10416, clocks per UART bit (100 MHz / 9600); minimum 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
PARITY_EN, 0, 1 inserts an even-parity bit after data bit 7.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_rdata  input  8  FIFO head byte; valid when fifo_empty=0
fifo_rd  output  1  one-cycle pop strobe to FIFO rd
tx  output  1  serial output; idle high; registered
tx_busy  output  1  high while a frame is on the line
tx_done  output  1  one-cycle pulse when a frame's last stop bit completes

Interface: one clock, clk. Reset rst is asynchronous and active-high.

Behaviour:
Reset values:
- tx=1, tx_busy=0, tx_done=0, fifo_rd=0.
- State IDLE, baud counter 0, bit index 0, shift register 0.

States: IDLE, START, DATA, PARITY, STOP.

Baud counter:
- Width $clog2(CLKS_PER_BIT).
- Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
- Wrap marks the end of a bit period.

fifo_rd (combinational):
- fifo_rd = !fifo_empty && (state==IDLE || end_of_frame).
- end_of_frame = STOP state, last stop bit, baud counter at CLKS_PER_BIT-1.
- Never asserted when fifo_empty=1, so the FIFO is never popped while empty.

Load (clock edge where fifo_rd=1):
- fifo_rdata is latched into the shift register.
- State becomes START, tx<=0, counter reset, tx_busy<=1.
- Latency: tx falls on the same edge that pops the FIFO.

START:
- tx=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.

DATA:
- tx = shift[idx], LSB first, each bit held CLKS_PER_BIT clocks.
- After bit 7: go to PARITY if PARITY_EN=1, otherwise go to STOP.

PARITY:
- tx = XOR of the 8 data bits (even parity).
- Held CLKS_PER_BIT clocks, then go to STOP.

STOP:
- tx=1 for STOP_BITS*CLKS_PER_BIT clocks.
- At end_of_frame, tx_done pulses high for one cycle.
- If fifo_empty=0 at end_of_frame: pop and go straight to START. The frames are back-to-back with zero idle clocks, and tx_busy stays high.
- Otherwise go to IDLE with tx_busy<=0.

Frame length:
- (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT clocks exactly.

Input sampling:
- fifo_empty/fifo_rdata changes during a frame have no effect.
- Only the load edge samples fifo_rdata.

Reset mid-frame:
- tx returns to 1 asynchronously and the in-flight byte is discarded (it was already popped).
- After release: IDLE; a pop occurs only if the FIFO is non-empty.

tx is driven from a flop only: no combinational glitches.

Test Plan:
1. CLKS_PER_BIT=4. Push 0x55 into an empty FIFO → exactly one fifo_rd pulse. tx holds 0,1,0,1,0,1,0,1,0,1, each bit for 4 clocks (40 clocks). tx_done pulses once at clock 40 and tx_busy falls.
2. Push 0xA5, 0x3C, 0xFF back-to-back → 3 fifo_rd pulses exactly 40 clocks apart. tx_busy is high for 120 contiguous clocks. Decoded bytes are 0xA5, 0x3C, 0xFF in order. No extra pop after 0xFF.
3. FIFO empty for 200 clocks → tx=1 throughout; fifo_rd, tx_busy and tx_done all stay 0.
4. Assert rst asynchronously during data bit 3 of 0x81 → tx=1 and tx_busy=0 immediately. With the FIFO empty after release, there is no fifo_rd and tx stays 1.
5. PARITY_EN=1, byte 0x07 → the parity bit is 1 and the frame is 11 bits (44 clocks). With byte 0x03, the parity bit is 0.
6. STOP_BITS=2, byte 0x00 → tx is low for 36 clocks, then high for 8 clocks. The next byte's start bit begins immediately after, with no gap.
